// File: rtl/timer_counter_bank.sv
// 16 x 16-bit countdown cell bank for the text display: masked inc/dec edits plus tick-driven countdown.
// Optional build macro PRESET_RELOAD_EN: snapshot cells at run start and restore the run cells on leaving DONE.
module timer_counter_bank #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_DIV = CLK_HZ,
  parameter int MAX_VAL  = 9999
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc_pulse,
  input  logic         dec_pulse,
  input  logic         ss_pulse,
  input  logic         clr_pulse,
  input  logic [3:0]   row_mask,
  input  logic [3:0]   col_mask,
  output logic [255:0] data_raw,
  output logic         running,
  output logic         done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   run_sel_q, run_sel_d;
  logic [15:0]   sel;
  logic [15:0]   cells_q [16];
  logic [15:0]   cells_d [16];
`ifdef PRESET_RELOAD_EN
  logic [15:0]   snap_q [16];
  logic [15:0]   snap_d [16];
`endif

  logic tick;
  logic any_sel_nz;
  logic run_all_zero;
  logic run_zero_after_tick;
  logic edit_ok;

  for (genvar k = 0; k < 16; k++) begin : g_cell
    assign sel[k] = row_mask[k/4] & col_mask[k%4];
    assign data_raw[255-16*k -: 16] = cells_q[k];
  end

  assign tick    = (state_q == S_RUN) && (presc_q == PW'(TICK_DIV - 1));
  assign edit_ok = !clr_pulse && !ss_pulse && (state_q == S_IDLE || state_q == S_PAUSE);

  // A run cell holding 0 or 1 reads 0 after the tick, since zero cells are not decremented.
  always_comb begin
    any_sel_nz          = 1'b0;
    run_all_zero        = 1'b1;
    run_zero_after_tick = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (sel[k] && cells_q[k] != 16'd0) any_sel_nz = 1'b1;
      if (run_sel_q[k] && cells_q[k] != 16'd0) run_all_zero = 1'b0;
      if (run_sel_q[k] && cells_q[k] > 16'd1) run_zero_after_tick = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr_pulse) begin
      state_d = S_IDLE;
    end else if (ss_pulse) begin
      case (state_q)
        S_IDLE:  if (any_sel_nz) state_d = S_RUN;
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = run_all_zero ? S_DONE : S_RUN;
        default: state_d = S_IDLE;
      endcase
    end else if (tick && run_zero_after_tick) begin
      state_d = S_DONE;
    end
  end

  always_comb begin
    running = (state_q == S_RUN);
    done    = (state_q == S_DONE);
  end

  always_comb begin
    presc_d   = presc_q;
    run_sel_d = run_sel_q;
    for (int k = 0; k < 16; k++) cells_d[k] = cells_q[k];
`ifdef PRESET_RELOAD_EN
    for (int k = 0; k < 16; k++) snap_d[k] = snap_q[k];
`endif
    if (clr_pulse) begin
      presc_d = '0;
      for (int k = 0; k < 16; k++) cells_d[k] = 16'd0;
`ifdef PRESET_RELOAD_EN
      for (int k = 0; k < 16; k++) snap_d[k] = 16'd0;
`endif
    end else begin
      // The prescaler advances on every RUN cycle, including the one that pauses.
      if (state_q == S_RUN) begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          for (int k = 0; k < 16; k++)
            if (run_sel_q[k] && cells_q[k] != 16'd0) cells_d[k] = cells_q[k] - 16'd1;
        end
      end
      if (state_q == S_IDLE && ss_pulse && any_sel_nz) begin
        run_sel_d = sel;
        presc_d   = '0;
`ifdef PRESET_RELOAD_EN
        for (int k = 0; k < 16; k++) snap_d[k] = cells_q[k];
`endif
      end
`ifdef PRESET_RELOAD_EN
      if (state_q == S_DONE && ss_pulse) begin
        for (int k = 0; k < 16; k++)
          if (run_sel_q[k]) cells_d[k] = snap_q[k];
      end
`endif
      if (edit_ok && inc_pulse) begin
        for (int k = 0; k < 16; k++)
          if (sel[k] && cells_q[k] < 16'(MAX_VAL)) cells_d[k] = cells_q[k] + 16'd1;
      end else if (edit_ok && dec_pulse) begin
        for (int k = 0; k < 16; k++)
          if (sel[k] && cells_q[k] != 16'd0) cells_d[k] = cells_q[k] - 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q   <= '0;
      run_sel_q <= '0;
      for (int k = 0; k < 16; k++) cells_q[k] <= 16'd0;
`ifdef PRESET_RELOAD_EN
      for (int k = 0; k < 16; k++) snap_q[k] <= 16'd0;
`endif
    end else begin
      presc_q   <= presc_d;
      run_sel_q <= run_sel_d;
      for (int k = 0; k < 16; k++) cells_q[k] <= cells_d[k];
`ifdef PRESET_RELOAD_EN
      for (int k = 0; k < 16; k++) snap_q[k] <= snap_d[k];
`endif
    end
  end

endmodule

// File: tb/tb_timer_counter_bank.sv
// Bench for timer_counter_bank: directed scenarios with literal expectations plus a per-cycle model compare.
module tb_timer_counter_bank;
  localparam int TICK_DIV = 4;
  localparam int MAX_VAL  = 9999;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         inc_pulse = 1'b0, dec_pulse = 1'b0, ss_pulse = 1'b0, clr_pulse = 1'b0;
  logic [3:0]   row_mask = 4'd0, col_mask = 4'd0;
  logic [255:0] data_raw;
  logic         running, done;

  int checks = 0;
  int errors = 0;

  timer_counter_bank #(.CLK_HZ(1000), .TICK_DIV(TICK_DIV), .MAX_VAL(MAX_VAL)) dut (
    .clk(clk), .reset_n(reset_n), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .ss_pulse(ss_pulse), .clr_pulse(clr_pulse), .row_mask(row_mask), .col_mask(col_mask),
    .data_raw(data_raw), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: cell values, run set and elapsed run cycles since the last tick.
  int m_cell [16];
  int m_snap [16];
  bit m_run  [16];
  int m_mode = M_IDLE;
  int m_phase = 0;
  bit m_valid = 0;

  function automatic bit picked(int k);
    return row_mask[k/4] && col_mask[k%4];
  endfunction

  function automatic bit run_cells_zero();
    for (int k = 0; k < 16; k++) if (m_run[k] && m_cell[k] != 0) return 0;
    return 1;
  endfunction

  task automatic advance_run(output bit ticked);
    ticked = 0;
    m_phase++;
    if (m_phase == TICK_DIV) begin
      m_phase = 0;
      ticked = 1;
      for (int k = 0; k < 16; k++) if (m_run[k] && m_cell[k] > 0) m_cell[k]--;
    end
  endtask

  task automatic model_step();
    bit t;
    bit nz;
    if (clr_pulse) begin
      for (int k = 0; k < 16; k++) begin m_cell[k] = 0; m_snap[k] = 0; end
      m_mode = M_IDLE; m_phase = 0;
    end else if (ss_pulse) begin
      case (m_mode)
        M_IDLE: begin
          nz = 0;
          for (int k = 0; k < 16; k++) if (picked(k) && m_cell[k] != 0) nz = 1;
          if (nz) begin
            for (int k = 0; k < 16; k++) begin m_run[k] = picked(k); m_snap[k] = m_cell[k]; end
            m_phase = 0; m_mode = M_RUN;
          end
        end
        M_RUN: begin advance_run(t); m_mode = M_PAUSE; end
        M_PAUSE: m_mode = run_cells_zero() ? M_DONE : M_RUN;
        default: begin
`ifdef PRESET_RELOAD_EN
          for (int k = 0; k < 16; k++) if (m_run[k]) m_cell[k] = m_snap[k];
`endif
          m_mode = M_IDLE;
        end
      endcase
    end else if (m_mode == M_RUN) begin
      advance_run(t);
      if (t && run_cells_zero()) m_mode = M_DONE;
    end else if (m_mode == M_IDLE || m_mode == M_PAUSE) begin
      for (int k = 0; k < 16; k++) begin
        if (picked(k) && inc_pulse && m_cell[k] < MAX_VAL) m_cell[k]++;
        else if (picked(k) && !inc_pulse && dec_pulse && m_cell[k] > 0) m_cell[k]--;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 16; k++) begin m_cell[k] = 0; m_snap[k] = 0; m_run[k] = 0; end
      m_mode = M_IDLE; m_phase = 0; m_valid = 1;
    end else if (m_valid) begin
      model_step();
    end
  end

  always @(negedge clk) begin
    logic [255:0] exp;
    if (m_valid) begin
      for (int k = 0; k < 16; k++) exp[255-16*k -: 16] = 16'(m_cell[k]);
      check("model_data", data_raw, exp);
      check("model_running", {255'd0, running}, {255'd0, m_mode == M_RUN});
      check("model_done", {255'd0, done}, {255'd0, m_mode == M_DONE});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_inc(input int n);
    repeat (n) begin inc_pulse = 1'b1; step(1); inc_pulse = 1'b0; end
  endtask

  task automatic pulse_ss();
    ss_pulse = 1'b1; step(1); ss_pulse = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_pulse = 1'b1; step(1); clr_pulse = 1'b0;
  endtask

  initial begin
    int waited;
    logic [15:0] exp_c3;
    step(2);
    reset_n = 1'b1;
    check("reset_data", data_raw, 256'd0);
    check("reset_running", {255'd0, running}, 256'd0);
    check("reset_done", {255'd0, done}, 256'd0);

    // Scenario 1: three increments of cell 0; an empty row mask edits nothing.
    row_mask = 4'b0001; col_mask = 4'b0001;
    pulse_inc(3);
    check("s1_cell0", {240'd0, data_raw[255:240]}, 256'd3);
    check("s1_others", {16'd0, data_raw[239:0]}, 256'd0);
    row_mask = 4'b0000;
    pulse_inc(1);
    check("s1_empty_mask", {240'd0, data_raw[255:240]}, 256'd3);

    // Scenario 2: countdown from 2 reaches 0 and DONE after 8 clocks.
    pulse_clr();
    row_mask = 4'b0001; col_mask = 4'b0001;
    pulse_inc(2);
    pulse_ss();
    check("s2_running", {255'd0, running}, 256'd1);
    step(3);
    check("s2_cell0_e3", {240'd0, data_raw[255:240]}, 256'd2);
    step(1);
    check("s2_cell0_e4", {240'd0, data_raw[255:240]}, 256'd1);
    step(3);
    check("s2_running_e7", {255'd0, running}, 256'd1);
    step(1);
    check("s2_cell0_e8", {240'd0, data_raw[255:240]}, 256'd0);
    check("s2_done", {255'd0, done}, 256'd1);
    check("s2_not_running", {255'd0, running}, 256'd0);

    // Scenario 3: start with all-zero selection ignored, dec floors, inc saturates.
    pulse_clr();
    row_mask = 4'b1111; col_mask = 4'b1111;
    pulse_ss();
    check("s3_ss_ignored", {255'd0, running}, 256'd0);
    dec_pulse = 1'b1; step(1); dec_pulse = 1'b0;
    check("s3_dec_floor", data_raw, 256'd0);
    row_mask = 4'b0010; col_mask = 4'b0010;
    inc_pulse = 1'b1; step(MAX_VAL); inc_pulse = 1'b0;
    check("s3_cell5_max", {240'd0, data_raw[175:160]}, 256'd9999);
    pulse_inc(1);
    check("s3_cell5_sat", {240'd0, data_raw[175:160]}, 256'd9999);

    // Scenario 4: pause two cycles into a run; prescaler position survives the pause.
    pulse_clr();
    row_mask = 4'b0001; col_mask = 4'b0001;
    pulse_inc(5);
    pulse_ss();
    step(1);
    pulse_ss();
    step(10);
    check("s4_paused_val", {240'd0, data_raw[255:240]}, 256'd5);
    check("s4_paused_run", {255'd0, running}, 256'd0);
    pulse_ss();
    check("s4_resumed", {255'd0, running}, 256'd1);
    step(1);
    check("s4_cell0_p1", {240'd0, data_raw[255:240]}, 256'd5);
    step(1);
    check("s4_cell0_p2", {240'd0, data_raw[255:240]}, 256'd4);

    // Scenario 5: clear wins over a simultaneous increment while running.
    clr_pulse = 1'b1; inc_pulse = 1'b1; step(1); clr_pulse = 1'b0; inc_pulse = 1'b0;
    check("s5_data", data_raw, 256'd0);
    check("s5_running", {255'd0, running}, 256'd0);
    check("s5_done", {255'd0, done}, 256'd0);

    // Scenario 6: run cell 3 to DONE, then leave DONE.
    row_mask = 4'b0001; col_mask = 4'b1000;
    pulse_inc(3);
    check("s6_cell3_set", {240'd0, data_raw[207:192]}, 256'd3);
    pulse_ss();
    waited = 0;
    while (!done && waited < 40) begin step(1); waited++; end
    check("s6_reached_done", {255'd0, done}, 256'd1);
    pulse_ss();
`ifdef PRESET_RELOAD_EN
    exp_c3 = 16'd3;
`else
    exp_c3 = 16'd0;
`endif
    check("s6_cell3_after", {240'd0, data_raw[207:192]}, {240'd0, exp_c3});
    check("s6_idle_done", {255'd0, done}, 256'd0);
    check("s6_idle_running", {255'd0, running}, 256'd0);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
